uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 155 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin, burst-locked arbiter that merges NUM_SRC AXI4-Stream byte
//   sources into one UART TX byte stream. Every accepted source byte goes out
//   as a two-byte frame: the source's header code, then the data byte. A grant
//   is held until the source's tlast, MAX_BURST beats, or the source going
//   idle, after which the round-robin pointer moves past the granted source.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   src_tdata         NUM_SRC packed bytes, source i at [8i+7:8i]
//   src_tvalid/tlast  per-source valid / end of packet
//   src_tready        per-source ready (only the granted source, only in load)
//   uart_out_t*       byte stream towards the UART transmitter
//   grant_idx         currently or most recently granted source
//   busy              arbiter is not idle
module uart_tx_arbiter #(
   parameter int unsigned              DATA_WIDTH  = 8,
   parameter int unsigned              NUM_SRC     = 4,
   parameter int unsigned              MAX_BURST   = 16,
   parameter logic [NUM_SRC*8-1:0]     SRC_HEADERS = {8'd5, 8'd2, 8'd3, 8'd0}
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_tdata,
   input  logic [NUM_SRC-1:0]              src_tvalid,
   output logic [NUM_SRC-1:0]              src_tready,
   input  logic [NUM_SRC-1:0]              src_tlast,
   output logic [DATA_WIDTH-1:0]           uart_out_tdata,
   output logic                            uart_out_tvalid,
   input  logic                            uart_out_tready,
   output logic                            uart_out_tlast,
   output logic [$clog2(NUM_SRC)-1:0]      grant_idx,
   output logic                            busy
);

   localparam int unsigned IW = $clog2(NUM_SRC);
   localparam int unsigned CW = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StHdr  = 2'd2,
      StData = 2'd3
   } state_e;

   state_e                  state_q;
   logic [IW-1:0]           rr_ptr_q;
   logic [IW-1:0]           grant_q;
   logic [CW-1:0]           beat_cnt_q;
   logic [DATA_WIDTH-1:0]   byte_q;
   logic                    last_q;

   logic [IW-1:0]           winner;
   logic [IW-1:0]           scan;
   logic                    found;
   logic [IW-1:0]           next_ptr;
   logic [DATA_WIDTH-1:0]   sel_data;
   logic                    sel_valid;
   logic                    sel_last;
   logic [DATA_WIDTH-1:0]   hdr_byte;
   logic                    burst_end;

   // First valid source scanning rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
   always_comb begin
      found  = 1'b0;
      winner = rr_ptr_q;
      scan   = '0;
      for (int k = 0; k < int'(NUM_SRC); k++) begin
         scan = IW'((int'(rr_ptr_q) + k) % int'(NUM_SRC));
         if (!found && src_tvalid[scan]) begin
            found  = 1'b1;
            winner = scan;
         end
      end
   end

   assign next_ptr  = (grant_q == IW'(NUM_SRC - 1)) ? '0 : grant_q + IW'(1);
   assign sel_data  = src_tdata[int'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
   assign sel_valid = src_tvalid[grant_q];
   assign sel_last  = src_tlast[grant_q];
   assign hdr_byte  = SRC_HEADERS[int'(grant_q) * 8 +: 8];
   // The beat being loaded is the last one the cap allows.
   assign burst_end = (beat_cnt_q + CW'(1)) == CW'(MAX_BURST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         beat_cnt_q <= '0;
         byte_q     <= '0;
         last_q     <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (found) begin
                  grant_q    <= winner;
                  beat_cnt_q <= '0;
                  state_q    <= StLoad;
               end
            end
            StLoad: begin
               if (sel_valid) begin
                  byte_q  <= sel_data;
                  last_q  <= sel_last | burst_end;
                  state_q <= StHdr;
               end else begin
                  // Source went idle mid-burst: release without a tlast.
                  rr_ptr_q <= next_ptr;
                  state_q  <= StIdle;
               end
            end
            StHdr: begin
               if (uart_out_tready) begin
                  state_q <= StData;
               end
            end
            StData: begin
               if (uart_out_tready) begin
                  beat_cnt_q <= beat_cnt_q + CW'(1);
                  if (last_q) begin
                     rr_ptr_q <= next_ptr;
                     state_q  <= StIdle;
                  end else begin
                     state_q <= StLoad;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign grant_idx       = grant_q;
   assign busy            = (state_q != StIdle);
   assign uart_out_tvalid = (state_q == StHdr) || (state_q == StData);
   assign uart_out_tlast  = (state_q == StData) && last_q;

   always_comb begin
      uart_out_tdata = '0;
      case (state_q)
         StHdr:   uart_out_tdata = hdr_byte;
         StData:  uart_out_tdata = byte_q;
         default: uart_out_tdata = '0;
      endcase
   end

   always_comb begin
      src_tready = '0;
      if (state_q == StLoad) begin
         src_tready[grant_q] = 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: one default instance driven from
// per-source byte queues, plus a MAX_BURST = 2 instance under full load.
module tb_uart_tx_arbiter;

   typedef struct {
      logic [7:0] d;
      logic       l;
      logic [1:0] g;
      int         cyc;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic [31:0] src_tdata = '0;
   logic [3:0]  src_tvalid = '0;
   logic [3:0]  src_tready;
   logic [3:0]  src_tlast = '0;
   logic [7:0]  uart_out_tdata;
   logic        uart_out_tvalid;
   logic        uart_out_tready = 1'b1;
   logic        uart_out_tlast;
   logic [1:0]  grant_idx;
   logic        busy;

   logic [31:0] b_src_tdata = {8'h30, 8'h20, 8'h10, 8'h00};
   logic [3:0]  b_src_tvalid = '0;
   logic [3:0]  b_src_tready;
   logic [3:0]  b_src_tlast = '0;
   logic [7:0]  b_tdata;
   logic        b_tvalid;
   logic        b_tready = 1'b1;
   logic        b_tlast;
   logic [1:0]  b_grant;
   logic        b_busy;

   int          n_checks = 0;
   int          n_err = 0;
   int          cyc = 0;

   logic [7:0]  sq_d [4][$];
   logic        sq_l [4][$];
   logic [3:0]  acc = '0;
   beat_t       out_q [$];
   beat_t       b_out_q [$];
   logic [7:0]  hdr_tab [4] = '{8'h00, 8'h03, 8'h02, 8'h05};

   uart_tx_arbiter dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .src_tdata       (src_tdata),
      .src_tvalid      (src_tvalid),
      .src_tready      (src_tready),
      .src_tlast       (src_tlast),
      .uart_out_tdata  (uart_out_tdata),
      .uart_out_tvalid (uart_out_tvalid),
      .uart_out_tready (uart_out_tready),
      .uart_out_tlast  (uart_out_tlast),
      .grant_idx       (grant_idx),
      .busy            (busy)
   );

   uart_tx_arbiter #(.MAX_BURST(2)) dut_b2 (
      .clk             (clk),
      .rst_n           (rst_n),
      .src_tdata       (b_src_tdata),
      .src_tvalid      (b_src_tvalid),
      .src_tready      (b_src_tready),
      .src_tlast       (b_src_tlast),
      .uart_out_tdata  (b_tdata),
      .uart_out_tvalid (b_tvalid),
      .uart_out_tready (b_tready),
      .uart_out_tlast  (b_tlast),
      .grant_idx       (b_grant),
      .busy            (b_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Sample handshakes mid-cycle.
   always @(negedge clk) begin
      beat_t b;
      acc = src_tvalid & src_tready;
      if (uart_out_tvalid && uart_out_tready) begin
         b.d = uart_out_tdata; b.l = uart_out_tlast; b.g = grant_idx; b.cyc = cyc;
         out_q.push_back(b);
      end
      if (b_tvalid && b_tready) begin
         b.d = b_tdata; b.l = b_tlast; b.g = b_grant; b.cyc = cyc;
         b_out_q.push_back(b);
      end
   end

   // Source model: present queue heads, pop on accepted handshakes.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 4; i++) begin
         if (acc[i] && sq_d[i].size() != 0) begin
            void'(sq_d[i].pop_front());
            void'(sq_l[i].pop_front());
         end
         src_tvalid[i]      = (sq_d[i].size() != 0);
         src_tdata[8*i +: 8] = (sq_d[i].size() != 0) ? sq_d[i][0] : 8'h00;
         src_tlast[i]       = (sq_l[i].size() != 0) ? sq_l[i][0] : 1'b0;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input int s, input logic [7:0] d, input logic l);
      sq_d[s].push_back(d);
      sq_l[s].push_back(l);
   endtask

   function automatic bit srcs_empty();
      return (sq_d[0].size() + sq_d[1].size() + sq_d[2].size() + sq_d[3].size()) == 0;
   endfunction

   task automatic wait_idle(input string tag);
      int quiet = 0;
      for (int k = 0; k < 300 && quiet < 2; k++) begin
         @(negedge clk);
         if (!busy && srcs_empty()) quiet++;
         else quiet = 0;
      end
      if (quiet < 2) check_eq({tag, " idle timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_valid(input string tag);
      bit seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
         @(negedge clk);
         seen = uart_out_tvalid;
      end
      if (!seen) check_eq({tag, " valid timeout"}, 32'd0, 32'd1);
   endtask

   task automatic expect_out(input string tag, input logic [7:0] d, input logic l,
                             input logic [1:0] g);
      beat_t b;
      if (out_q.size() == 0) begin
         check_eq({tag, " missing"}, 32'd0, 32'd1);
         return;
      end
      b = out_q.pop_front();
      check_eq({tag, " data"}, 32'(b.d), 32'(d));
      check_eq({tag, " last"}, 32'(b.l), 32'(l));
      check_eq({tag, " grant"}, 32'(b.g), 32'(g));
   endtask

   task automatic set_ready(input logic r);
      @(posedge clk);
      #1;
      uart_out_tready = r;
   endtask

   task automatic check_zero_outputs(input string tag);
      check_eq({tag, " tvalid"}, 32'(uart_out_tvalid), 32'd0);
      check_eq({tag, " tdata"}, 32'(uart_out_tdata), 32'd0);
      check_eq({tag, " tlast"}, 32'(uart_out_tlast), 32'd0);
      check_eq({tag, " grant"}, 32'(grant_idx), 32'd0);
      check_eq({tag, " busy"}, 32'(busy), 32'd0);
      check_eq({tag, " src_tready"}, 32'(src_tready), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_zero_outputs("reset");
      check_eq("reset b_busy", 32'(b_busy), 32'd0);

      // Single source, normal burst.
      push(2, 8'hAA, 1'b0); push(2, 8'hBB, 1'b0); push(2, 8'hCC, 1'b1);
      wait_idle("t1");
      check_eq("t1 count", out_q.size(), 32'd6);
      if (out_q.size() >= 3) check_eq("t1 beat period", out_q[2].cyc - out_q[0].cyc, 32'd3);
      expect_out("t1 h0", 8'h02, 1'b0, 2'd2);
      expect_out("t1 d0", 8'hAA, 1'b0, 2'd2);
      expect_out("t1 h1", 8'h02, 1'b0, 2'd2);
      expect_out("t1 d1", 8'hBB, 1'b0, 2'd2);
      expect_out("t1 h2", 8'h02, 1'b0, 2'd2);
      expect_out("t1 d2", 8'hCC, 1'b1, 2'd2);
      check_eq("t1 busy", 32'(busy), 32'd0);

      // Scan resumes at src 3 after src 2's burst.
      push(0, 8'h01, 1'b1); push(3, 8'h31, 1'b1);
      wait_idle("t1b");
      check_eq("t1b count", out_q.size(), 32'd4);
      expect_out("t1b h3", 8'h05, 1'b0, 2'd3);
      expect_out("t1b d3", 8'h31, 1'b1, 2'd3);
      expect_out("t1b h0", 8'h00, 1'b0, 2'd0);
      expect_out("t1b d0", 8'h01, 1'b1, 2'd0);

      // Reset while parked in the data phase (rr_ptr is 1 beforehand).
      set_ready(1'b0);
      push(1, 8'h77, 1'b1);
      wait_valid("t5");
      check_eq("t5 hdr", 32'(uart_out_tdata), 32'h03);
      set_ready(1'b1);
      set_ready(1'b0);
      @(negedge clk);
      check_eq("t5 data", 32'(uart_out_tdata), 32'h77);
      check_eq("t5 data last", 32'(uart_out_tlast), 32'd1);
      expect_out("t5 h1", 8'h03, 1'b0, 2'd1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      uart_out_tready = 1'b1;
      @(negedge clk);
      check_zero_outputs("t5 after reset");
      push(0, 8'h0C, 1'b1); push(3, 8'h3C, 1'b1);
      wait_idle("t5b");
      check_eq("t5b count", out_q.size(), 32'd4);
      expect_out("t5b h0", 8'h00, 1'b0, 2'd0);
      expect_out("t5b d0", 8'h0C, 1'b1, 2'd0);
      expect_out("t5b h3", 8'h05, 1'b0, 2'd3);
      expect_out("t5b d3", 8'h3C, 1'b1, 2'd3);

      // Pointer wrap after src 3.
      push(3, 8'h3A, 1'b1);
      wait_idle("t6a");
      expect_out("t6a h3", 8'h05, 1'b0, 2'd3);
      expect_out("t6a d3", 8'h3A, 1'b1, 2'd3);
      push(0, 8'h0A, 1'b1); push(3, 8'h3B, 1'b1);
      wait_idle("t6b");
      check_eq("t6b count", out_q.size(), 32'd4);
      expect_out("t6b h0", 8'h00, 1'b0, 2'd0);
      expect_out("t6b d0", 8'h0A, 1'b1, 2'd0);
      expect_out("t6b h3", 8'h05, 1'b0, 2'd3);
      expect_out("t6b d3", 8'h3B, 1'b1, 2'd3);

      // Source goes idle mid-burst.
      push(1, 8'h11, 1'b0); push(3, 8'h33, 1'b1);
      wait_idle("t4");
      check_eq("t4 count", out_q.size(), 32'd4);
      expect_out("t4 h1", 8'h03, 1'b0, 2'd1);
      expect_out("t4 d1", 8'h11, 1'b0, 2'd1);
      expect_out("t4 h3", 8'h05, 1'b0, 2'd3);
      expect_out("t4 d3", 8'h33, 1'b1, 2'd3);

      // Backpressure during the header.
      set_ready(1'b0);
      push(2, 8'h5A, 1'b1);
      wait_valid("t3");
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         check_eq($sformatf("t3 stall%0d tdata", k), 32'(uart_out_tdata), 32'h02);
         check_eq($sformatf("t3 stall%0d tvalid", k), 32'(uart_out_tvalid), 32'd1);
         check_eq($sformatf("t3 stall%0d tlast", k), 32'(uart_out_tlast), 32'd0);
         check_eq($sformatf("t3 stall%0d src_tready", k), 32'(src_tready), 32'd0);
      end
      set_ready(1'b1);
      wait_idle("t3");
      check_eq("t3 count", out_q.size(), 32'd2);
      expect_out("t3 h2", 8'h02, 1'b0, 2'd2);
      expect_out("t3 d2", 8'h5A, 1'b1, 2'd2);

      // Fairness under full load on the MAX_BURST = 2 instance.
      @(posedge clk);
      #1 b_src_tvalid = 4'hF;
      for (int k = 0; k < 600 && b_out_q.size() < 32; k++) @(negedge clk);
      check_eq("t2 collected", 32'(b_out_q.size() >= 32), 32'd1);
      for (int r = 0; r < 2; r++) begin
         for (int s = 0; s < 4; s++) begin
            for (int j = 0; j < 2; j++) begin
               beat_t h, d;
               if (b_out_q.size() < 2) break;
               h = b_out_q.pop_front();
               d = b_out_q.pop_front();
               check_eq($sformatf("t2 r%0d s%0d b%0d hdr", r, s, j), 32'(h.d), 32'(hdr_tab[s]));
               check_eq($sformatf("t2 r%0d s%0d b%0d hlast", r, s, j), 32'(h.l), 32'd0);
               check_eq($sformatf("t2 r%0d s%0d b%0d data", r, s, j), 32'(d.d), 32'(s * 16));
               check_eq($sformatf("t2 r%0d s%0d b%0d dlast", r, s, j), 32'(d.l), 32'(j == 1));
            end
         end
      end
      @(posedge clk);
      #1 b_src_tvalid = 4'h0;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
